score_bcd_multi: RTL and testbench

Multi-channel, parametrised binary-to-BCD score converter feeding the seven-segment score display path. Each channel converts a BIN_WIDTH-bit binary score into DIGITS packed BCD digits, using a sequential shift-and-add-3 (double-dabble) engine. All channels convert in parallel from one update request. Values the digits cannot represent saturate to all nines with an overflow flag. Outputs change only at the commit cycle, so the display never shows partial results.

---
 rtl/score_pkg.sv | 40 ++++
 rtl/bcd_dabble_lane.sv | 44 ++++
 rtl/score_bcd_multi.sv | 137 +++++++++++++
 tb/tb_score_bcd_multi.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and helpers for the multi-channel binary-to-BCD score converter.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    // Widest digit count supported by the helpers below.
    localparam int MAX_DIGITS = 9;

    // Largest value representable in the given number of BCD digits.
    function automatic logic [63:0] pow10_minus1(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    // Packed BCD word with the low 'digits' nibbles set to 9.
    function automatic logic [4*MAX_DIGITS-1:0] bcd_all_nines(input int digits);
        logic [4*MAX_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[i*4 +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Bit counter width able to hold 0..bin_width.
    function automatic int cnt_width(input int bin_width);
        return $clog2(bin_width + 1);
    endfunction

endpackage

// File: rtl/bcd_dabble_lane.sv
// One channel of the double-dabble engine: binary shift register, BCD
// accumulator and the per-nibble add-3 correction.
module bcd_dabble_lane
    import score_pkg::*;
#(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [BIN_WIDTH-1:0]  din,
    output logic [DIGITS*4-1:0]   bcd
);

    logic [BIN_WIDTH-1:0] bin_sr;
    logic [DIGITS*4-1:0]  bcd_adj;

    // Add 3 to every nibble that would reach 10 or more after the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[d*4 +: 4] >= 4'd5) begin
                bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            end
        end
    end

    // Load clears the accumulator; each step shifts {bcd, bin} left by one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bin_sr <= '0;
            bcd    <= '0;
        end else if (load) begin
            bin_sr <= din;
            bcd    <= '0;
        end else if (step) begin
            bcd    <= {bcd_adj[DIGITS*4-2:0], bin_sr[BIN_WIDTH-1]};
            bin_sr <= bin_sr << 1;
        end
    end

endmodule

// File: rtl/score_bcd_multi.sv
// Multi-channel binary-to-BCD score converter. All channels convert in
// parallel from one update request; results appear together at commit.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for a request (or a request caught on a commit edge)
// ST_SHIFT  | one double-dabble step per edge, BIN_WIDTH edges in total
// ST_COMMIT | load score/overflow, pulse done, restart if a request is pending
module score_bcd_multi
    import score_pkg::*;
#(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3,
    parameter int CHANNELS  = 2
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [CHANNELS*BIN_WIDTH-1:0]  binary,
    input  logic                           update,
    output logic [CHANNELS*DIGITS*4-1:0]   score,
    output logic [CHANNELS-1:0]            overflow,
    output logic                           busy,
    output logic                           done
);

    localparam int                      CNT_W     = cnt_width(BIN_WIDTH);
    localparam logic [63:0]             MAX_VAL   = pow10_minus1(DIGITS);
    localparam logic [4*MAX_DIGITS-1:0] NINES_ALL = bcd_all_nines(DIGITS);
    localparam logic [DIGITS*4-1:0]     NINES     = NINES_ALL[DIGITS*4-1:0];
    localparam logic [CNT_W-1:0]        LAST_STEP = CNT_W'(BIN_WIDTH - 1);

    state_t               state;
    logic                 update_q;
    logic                 pending;
    logic [CNT_W-1:0]     cnt;
    logic [CHANNELS-1:0]  sat;
    logic [CHANNELS-1:0]  sat_next;
    logic                 req;
    logic                 lane_load;
    logic                 lane_step;
    logic [DIGITS*4-1:0]  lane_bcd [CHANNELS];

    assign req = update & ~update_q;

    // Lanes capture on the same edge the FSM leaves IDLE or restarts from COMMIT.
    always_comb begin
        lane_load = ((state == ST_IDLE) && (req || pending)) ||
                    ((state == ST_COMMIT) && pending);
        lane_step = (state == ST_SHIFT);
    end

    // Saturation is judged on the raw binary value being captured.
    always_comb begin
        sat_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sat_next[c] = 64'(binary[c*BIN_WIDTH +: BIN_WIDTH]) > MAX_VAL;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        bcd_dabble_lane #(
            .BIN_WIDTH(BIN_WIDTH),
            .DIGITS   (DIGITS)
        ) u_lane (
            .clock  (clock),
            .reset_n(reset_n),
            .load   (lane_load),
            .step   (lane_step),
            .din    (binary[c*BIN_WIDTH +: BIN_WIDTH]),
            .bcd    (lane_bcd[c])
        );
    end

    // Sequencer: edge detect, pending merge, bit counting and output commit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            update_q <= 1'b0;
            pending  <= 1'b0;
            cnt      <= '0;
            sat      <= '0;
            score    <= '0;
            overflow <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            update_q <= update;
            done     <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req || pending) begin
                        state   <= ST_SHIFT;
                        cnt     <= '0;
                        sat     <= sat_next;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    busy <= 1'b1;
                    if (req) begin
                        pending <= 1'b1;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    busy <= 1'b1;
                    for (int c = 0; c < CHANNELS; c++) begin
                        score[c*DIGITS*4 +: DIGITS*4] <= sat[c] ? NINES : lane_bcd[c];
                    end
                    overflow <= sat;
                    done     <= 1'b1;
                    if (pending) begin
                        // A request already waiting absorbs one arriving on this edge.
                        pending <= 1'b0;
                        sat     <= sat_next;
                        cnt     <= '0;
                        state   <= ST_SHIFT;
                    end else begin
                        // A request on this edge is held and started from IDLE.
                        pending <= req;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_multi.sv
// Bench for score_bcd_multi: a 3-digit and a 2-digit instance share stimulus;
// expected scores come from a decimal reference model.
module tb_score_bcd_multi;

    localparam int BW = 8;
    localparam int CH = 2;
    localparam int D3 = 3;
    localparam int D2 = 2;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic              update  = 1'b0;
    logic [CH*BW-1:0]  binary  = '0;

    logic [CH*D3*4-1:0] score3;
    logic [CH-1:0]      ovf3;
    logic               busy3;
    logic               done3;
    logic [CH*D2*4-1:0] score2;
    logic [CH-1:0]      ovf2;
    logic               busy2;
    logic               done2;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] exp_s3 = '0;
    logic [63:0] exp_s2 = '0;
    logic [1:0]  exp_o3 = '0;
    logic [1:0]  exp_o2 = '0;

    score_bcd_multi #(.BIN_WIDTH(BW), .DIGITS(D3), .CHANNELS(CH)) u_dut3 (
        .clock   (clock),
        .reset_n (reset_n),
        .binary  (binary),
        .update  (update),
        .score   (score3),
        .overflow(ovf3),
        .busy    (busy3),
        .done    (done3)
    );

    score_bcd_multi #(.BIN_WIDTH(BW), .DIGITS(D2), .CHANNELS(CH)) u_dut2 (
        .clock   (clock),
        .reset_n (reset_n),
        .binary  (binary),
        .update  (update),
        .score   (score2),
        .overflow(ovf2),
        .busy    (busy2),
        .done    (done2)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    // Decimal digits of v, or all nines when v does not fit.
    function automatic logic [63:0] ref_lane(input int unsigned v, input int digits);
        logic [63:0] r;
        int unsigned x;
        int unsigned lim;
        r   = '0;
        lim = 32'd1;
        for (int i = 0; i < digits; i++) lim = lim * 32'd10;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[i*4 +: 4] = (v >= lim) ? 4'd9 : 4'(x % 32'd10);
            x = x / 32'd10;
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_score(input logic [15:0] b, input int digits);
        return ref_lane(32'(b[7:0]), digits) | (ref_lane(32'(b[15:8]), digits) << (4 * digits));
    endfunction

    function automatic logic [1:0] ref_ovf(input logic [15:0] b, input int digits);
        int unsigned lim;
        lim = 32'd1;
        for (int i = 0; i < digits; i++) lim = lim * 32'd10;
        return {32'(b[15:8]) >= lim, 32'(b[7:0]) >= lim};
    endfunction

    function automatic logic [7:0] pick();
        case ($urandom % 6)
            0:       return 8'd0;
            1:       return 8'd99;
            2:       return 8'd100;
            3:       return 8'd255;
            default: return 8'($urandom % 256);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_expect(input logic [15:0] b);
        exp_s3 = ref_score(b, D3);
        exp_o3 = ref_ovf(b, D3);
        exp_s2 = ref_score(b, D2);
        exp_o2 = ref_ovf(b, D2);
    endtask

    task automatic clear_expect();
        exp_s3 = '0;
        exp_o3 = '0;
        exp_s2 = '0;
        exp_o2 = '0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_score3"}, 64'(score3), exp_s3);
        chk({tag, "_ovf3"},   64'(ovf3),   64'(exp_o3));
        chk({tag, "_score2"}, 64'(score2), exp_s2);
        chk({tag, "_ovf2"},   64'(ovf2),   64'(exp_o2));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One busy cycle; outputs must hold unless this is the done cycle.
    task automatic cyc_chk(input string tag, input bit exp_done);
        step();
        chk({tag, "_busy3"}, 64'(busy3), 64'd1);
        chk({tag, "_busy2"}, 64'(busy2), 64'd1);
        chk({tag, "_done3"}, 64'(done3), 64'(exp_done));
        chk({tag, "_done2"}, 64'(done2), 64'(exp_done));
        if (!exp_done) chk_outputs({tag, "_hold"});
    endtask

    task automatic idle_chk(input string tag);
        step();
        chk({tag, "_busy3"}, 64'(busy3), 64'd0);
        chk({tag, "_busy2"}, 64'(busy2), 64'd0);
        chk({tag, "_done3"}, 64'(done3), 64'd0);
        chk({tag, "_done2"}, 64'(done2), 64'd0);
        chk_outputs({tag, "_idle"});
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_busy3"}, 64'(busy3), 64'd0);
        chk({tag, "_done3"}, 64'(done3), 64'd0);
        chk({tag, "_busy2"}, 64'(busy2), 64'd0);
        chk({tag, "_done2"}, 64'(done2), 64'd0);
        chk_outputs(tag);
    endtask

    // Single request; binary optionally disturbed after capture.
    task automatic convert(input logic [15:0] b, input bit scramble, input string tag);
        binary = b;
        update = 1'b1;
        cyc_chk({tag, "_e0"}, 1'b0);
        update = 1'b0;
        if (scramble) binary = 16'($urandom);
        for (int k = 1; k <= BW + 1; k++) cyc_chk(tag, k == BW + 1);
        set_expect(b);
        chk_outputs({tag, "_result"});
        idle_chk({tag, "_after"});
    endtask

    initial begin
        logic [7:0]  r8;
        logic [15:0] b;

        // Reset values
        #3;
        clear_expect();
        reset_chk("rst_init");
        step();
        step();
        reset_n = 1'b1;
        repeat (3) idle_chk("post_rst");

        // Basic conversion
        convert({8'd7, 8'd11}, 1'b0, "basic");
        chk("basic_const", 64'(score3), 64'h007011);

        // Full range, scores hold between requests
        convert({8'd0, 8'd255}, 1'b0, "full255");
        chk("full255_const", 64'(score3), 64'h000255);
        repeat (4) idle_chk("full_gap");
        convert({8'd0, 8'd100}, 1'b0, "full100");
        chk("full100_const", 64'(score3), 64'h000100);

        // Saturation on the two-digit instance
        convert({8'd99, 8'd123}, 1'b0, "sat");
        chk("sat_score2", 64'(score2), 64'h9999);
        chk("sat_ovf2",   64'(ovf2),   64'h1);
        chk("sat_score3", 64'(score3), 64'h099123);

        // Asynchronous reset while idle
        #2;
        reset_n = 1'b0;
        #1;
        clear_expect();
        reset_chk("rst_idle");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (4) idle_chk("rst_idle_quiet");

        // Pending merge: two requests during shifting give one extra conversion
        r8 = pick();
        binary = {r8, 8'd5};
        update = 1'b1;
        cyc_chk("pm_e0", 1'b0);
        update = 1'b0;
        repeat (3) cyc_chk("pm_shift", 1'b0);
        binary = {r8, 8'd42};
        update = 1'b1;
        cyc_chk("pm_req1", 1'b0);
        update = 1'b0;
        cyc_chk("pm_gap", 1'b0);
        update = 1'b1;
        cyc_chk("pm_req2", 1'b0);
        update = 1'b0;
        for (int k = 7; k <= BW + 1; k++) cyc_chk("pm_first", k == BW + 1);
        set_expect({r8, 8'd5});
        chk_outputs("pm_first_res");
        chk("pm_first_ch0", 64'(score3[11:0]), 64'h005);
        for (int k = 1; k <= BW + 1; k++) cyc_chk("pm_second", k == BW + 1);
        set_expect({r8, 8'd42});
        chk_outputs("pm_second_res");
        chk("pm_second_ch0", 64'(score3[11:0]), 64'h042);
        repeat (12) idle_chk("pm_no_third");

        // Randomized conversions
        for (int i = 0; i < 40; i++) begin
            b[7:0]  = pick();
            b[15:8] = pick();
            convert(b, ($urandom % 2) == 1, "rand");
            repeat ($urandom_range(0, 2)) idle_chk("rand_gap");
        end

        // Reset in the middle of a conversion, update held through release
        if (score3 == '0) convert({8'd1, 8'd1}, 1'b0, "pre_rst");
        binary = {pick(), pick()};
        update = 1'b1;
        cyc_chk("rm_e0", 1'b0);
        update = 1'b0;
        repeat (4) cyc_chk("rm_shift", 1'b0);
        #2;
        reset_n = 1'b0;
        update  = 1'b1;
        #1;
        clear_expect();
        reset_chk("rm_rst");
        b = {pick(), pick()};
        binary = b;
        repeat (2) begin
            step();
            reset_chk("rm_hold");
        end
        reset_n = 1'b1;
        for (int k = 0; k <= BW + 1; k++) cyc_chk("rm_conv", k == BW + 1);
        set_expect(b);
        chk_outputs("rm_result");
        repeat (12) idle_chk("rm_held_high");
        update = 1'b0;
        idle_chk("rm_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
